// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encoding, IR capture pattern and the
// fill value used to build the default bypass opcode.
package jtag_pkg;

  // Fixed 4-bit TAP state encoding (classic 1149.1 numbering, TLR = 4'hF).
  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR        = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR        = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_IDLE         = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_t;

  // Low two bits loaded into the IR shift register in Capture-IR.
  localparam logic [1:0] IR_CAPTURE_PAT = 2'b01;

  // Every bit of the default bypass opcode takes this value.
  localparam logic BYPASS_OP_FILL = 1'b0;

endpackage

// File: rtl/tap_fsm.sv
// IEEE 1149.1 TAP state machine: state register plus next-state logic only.
module tap_fsm
  import jtag_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tms,
  output tap_state_t o_state
);

  tap_state_t r_state;

  // One TMS-selected transition per clock; async reset parks the TAP in TLR.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= TEST_LOGIC_RESET;
    end else begin
      case (r_state)
        TEST_LOGIC_RESET: r_state <= i_tms ? TEST_LOGIC_RESET : RUN_IDLE;
        RUN_IDLE:         r_state <= i_tms ? SELECT_DR        : RUN_IDLE;
        SELECT_DR:        r_state <= i_tms ? SELECT_IR        : CAPTURE_DR;
        CAPTURE_DR:       r_state <= i_tms ? EXIT1_DR         : SHIFT_DR;
        SHIFT_DR:         r_state <= i_tms ? EXIT1_DR         : SHIFT_DR;
        EXIT1_DR:         r_state <= i_tms ? UPDATE_DR        : PAUSE_DR;
        PAUSE_DR:         r_state <= i_tms ? EXIT2_DR         : PAUSE_DR;
        EXIT2_DR:         r_state <= i_tms ? UPDATE_DR        : SHIFT_DR;
        UPDATE_DR:        r_state <= i_tms ? SELECT_DR        : RUN_IDLE;
        SELECT_IR:        r_state <= i_tms ? TEST_LOGIC_RESET : CAPTURE_IR;
        CAPTURE_IR:       r_state <= i_tms ? EXIT1_IR         : SHIFT_IR;
        SHIFT_IR:         r_state <= i_tms ? EXIT1_IR         : SHIFT_IR;
        EXIT1_IR:         r_state <= i_tms ? UPDATE_IR        : PAUSE_IR;
        PAUSE_IR:         r_state <= i_tms ? EXIT2_IR         : PAUSE_IR;
        EXIT2_IR:         r_state <= i_tms ? UPDATE_IR        : SHIFT_IR;
        UPDATE_IR:        r_state <= i_tms ? SELECT_DR        : RUN_IDLE;
        default:          r_state <= TEST_LOGIC_RESET;
      endcase
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/tap_ir_ctrl.sv
// TAP controller front end: runs the TAP FSM, owns the instruction register
// (capture/shift/update), decodes DR-path strobes and muxes TDO.
module tap_ir_ctrl
  import jtag_pkg::*;
#(
  parameter int                     instr_width = 4,
  parameter logic [instr_width-1:0] bypass_op   = {instr_width{BYPASS_OP_FILL}}
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   tms,
  input  logic                   tdi,
  input  logic                   dr_tdo,
  output logic                   tdo,
  output logic                   tdo_en,
  output logic [instr_width-1:0] ir_out,
  output logic                   capture_dr,
  output logic                   shift_dr,
  output logic                   update_dr,
  output tap_state_t             tap_state
);

  tap_state_t             w_state;
  logic [instr_width-1:0] r_ir_shift;
  logic [instr_width-1:0] r_ir_out;

  tap_fsm u_tap_fsm (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_tms   (tms),
    .o_state (w_state)
  );

  // IR shift/update path, acting on the state current at each edge. The shift
  // also runs on the Shift-IR exit edge so the last TDI bit is kept. Pause and
  // all DR states leave both registers alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ir_shift <= '0;
      r_ir_out   <= bypass_op;
    end else begin
      case (w_state)
        CAPTURE_IR:       r_ir_shift <= {{(instr_width-2){1'b0}}, IR_CAPTURE_PAT};
        SHIFT_IR:         r_ir_shift <= {tdi, r_ir_shift[instr_width-1:1]};
        UPDATE_IR:        r_ir_out   <= r_ir_shift;
        TEST_LOGIC_RESET: r_ir_out   <= bypass_op;
        default:          ;
      endcase
    end
  end

  // TDO source selection from the registered state; quiet outside shifts.
  always_comb begin
    tdo = 1'b0;
    case (w_state)
      SHIFT_IR: tdo = r_ir_shift[0];
      SHIFT_DR: tdo = dr_tdo;
      default:  tdo = 1'b0;
    endcase
  end

  assign tdo_en     = (w_state == SHIFT_IR) || (w_state == SHIFT_DR);
  assign capture_dr = (w_state == CAPTURE_DR);
  assign shift_dr   = (w_state == SHIFT_DR);
  assign update_dr  = (w_state == UPDATE_DR);
  assign ir_out     = r_ir_out;
  assign tap_state  = w_state;

endmodule

// File: tb/tb_tap_ir_ctrl.sv
// Bench for tap_ir_ctrl: scenario tasks plus a randomized walk, all checked
// against a table-driven TAP/IR model kept here.
module tb_tap_ir_ctrl;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic tms     = 1'b1;
  logic tdi     = 1'b0;
  logic dr_tdo  = 1'b0;

  logic         tdo;
  logic         tdo_en;
  logic [W-1:0] ir_out;
  logic         capture_dr;
  logic         shift_dr;
  logic         update_dr;
  logic [3:0]   tap_state;

  always #5 clk = ~clk;

  tap_ir_ctrl #(.instr_width(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tms        (tms),
    .tdi        (tdi),
    .dr_tdo     (dr_tdo),
    .tdo        (tdo),
    .tdo_en     (tdo_en),
    .ir_out     (ir_out),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .tap_state  (tap_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // State index in the order the 1149.1 graph is usually listed:
  // 0 TLR 1 RTI 2 SelDR 3 CapDR 4 ShDR 5 Ex1DR 6 PauDR 7 Ex2DR 8 UpdDR
  // 9 SelIR 10 CapIR 11 ShIR 12 Ex1IR 13 PauIR 14 Ex2IR 15 UpdIR
  int         nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int         nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  logic [3:0] enc  [16] = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0,
                            4'h5, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};

  int           m_st = 0;
  logic [W-1:0] m_sh = '0;
  logic [W-1:0] m_out = '0;

  function automatic logic exp_tdo();
    if (m_st == 11) return m_sh[0];
    if (m_st == 4)  return dr_tdo;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_st  = 0;
    m_sh  = '0;
    m_out = '0;
  endtask

  // ---------------- driver tasks ----------------
  // Drive TMS/TDI at the falling edge, clock once, advance the model, and
  // return 1 time unit after the rising edge.
  task automatic step(input logic t, input logic d);
    @(negedge clk);
    tms = t;
    tdi = d;
    @(posedge clk);
    if (m_st == 10)      m_sh = W'(1);
    else if (m_st == 11) m_sh = (m_sh >> 1) | (W'(d) << (W - 1));
    else if (m_st == 15) m_out = m_sh;
    else if (m_st == 0)  m_out = '0;
    m_st = t ? nxt1[m_st] : nxt0[m_st];
    #1;
  endtask

  task automatic set_dr(input logic v);
    dr_tdo = v;
    #1;
  endtask

  // From RTI: full IR scan of value v, ending back in RTI.
  task automatic load_ir(input logic [W-1:0] v);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < W; i++) step(i == W - 1, v[i]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (tap_state !== 4'hF) begin
      errors++; $display("FAIL reset_state: got %h expected %h", tap_state, 4'hF);
    end
    checks++;
    if (ir_out !== 4'b0000) begin
      errors++; $display("FAIL reset_ir_out: got %b expected %b", ir_out, 4'b0000);
    end
    checks++;
    if ({capture_dr, shift_dr, update_dr, tdo, tdo_en} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b",
                         {capture_dr, shift_dr, update_dr, tdo, tdo_en}, 5'b0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if (tap_state !== 4'hC || tap_state !== enc[m_st]) begin
      errors++; $display("FAIL release_rti: got %h expected %h", tap_state, 4'hC);
    end
    checks++;
    if ({ir_out, capture_dr, shift_dr, update_dr, tdo_en} !== 8'b0) begin
      errors++; $display("FAIL release_outputs: got %b expected %b",
                         {ir_out, capture_dr, shift_dr, update_dr, tdo_en}, 8'b0);
    end
  endtask

  task automatic test_ir_capture_shift();
    logic b_tdi [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic b_tdo [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if (tap_state !== 4'hA) begin
      errors++; $display("FAIL enter_shift_ir: got %h expected %h", tap_state, 4'hA);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tdo !== b_tdo[i] || tdo !== exp_tdo() || tdo_en !== 1'b1) begin
        errors++; $display("FAIL ir_tdo[%0d]: got tdo=%b en=%b expected tdo=%b en=1",
                           i, tdo, tdo_en, b_tdo[i]);
      end
      step(i == 3, b_tdi[i]);
    end
    checks++;
    if (tap_state !== 4'h9 || tdo_en !== 1'b0) begin
      errors++; $display("FAIL exit1_ir: got %h en=%b expected %h en=0", tap_state, tdo_en, 4'h9);
    end
    step(1'b1, 1'b0);
    checks++;
    if (tap_state !== 4'hD || ir_out !== m_out) begin
      errors++; $display("FAIL update_ir_hold: got %h/%b expected %h/%b",
                         tap_state, ir_out, 4'hD, m_out);
    end
    step(1'b0, 1'b0);
    checks++;
    if (ir_out !== 4'b0111 || ir_out !== m_out) begin
      errors++; $display("FAIL ir_load_0111: got %b expected %b", ir_out, 4'b0111);
    end
    checks++;
    if (tap_state !== 4'hC) begin
      errors++; $display("FAIL back_to_rti: got %h expected %h", tap_state, 4'hC);
    end
  endtask

  task automatic test_tms_reset();
    load_ir(4'b0010);
    checks++;
    if (ir_out !== 4'b0010) begin
      errors++; $display("FAIL ir_load_0010: got %b expected %b", ir_out, 4'b0010);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if (tap_state !== 4'h2 || shift_dr !== 1'b1) begin
      errors++; $display("FAIL enter_shift_dr: got %h sh=%b expected %h sh=1",
                         tap_state, shift_dr, 4'h2);
    end
    repeat (5) step(1'b1, 1'b0);
    checks++;
    if (tap_state !== 4'hF) begin
      errors++; $display("FAIL five_tms_tlr: got %h expected %h", tap_state, 4'hF);
    end
    step(1'b1, 1'b0);
    checks++;
    if (ir_out !== 4'b0000 || ir_out !== m_out) begin
      errors++; $display("FAIL tlr_bypass: got %b expected %b", ir_out, 4'b0000);
    end
    // Five TMS=1 cycles from arbitrary reachable states.
    for (int k = 0; k < 6; k++) begin
      int n;
      n = $urandom_range(1, 20);
      for (int j = 0; j < n; j++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat (5) step(1'b1, 1'b0);
      checks++;
      if (tap_state !== 4'hF || m_st != 0) begin
        errors++; $display("FAIL random_five_tms[%0d]: got %h expected %h", k, tap_state, 4'hF);
      end
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_pause_ir();
    logic [W-1:0] b;
    b = W'($urandom_range(0, 15));
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, b[0]);
    step(1'b1, b[1]);
    step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tap_state !== 4'hB || tdo !== 1'b0 || tdo_en !== 1'b0) begin
        errors++; $display("FAIL pause_ir[%0d]: got %h tdo=%b en=%b expected %h 0 0",
                           i, tap_state, tdo, tdo_en, 4'hB);
      end
      step(i == 2, $urandom_range(0, 1) == 1);
    end
    checks++;
    if (tap_state !== 4'h8) begin
      errors++; $display("FAIL exit2_ir: got %h expected %h", tap_state, 4'h8);
    end
    step(1'b0, 1'b0);
    checks++;
    if (tap_state !== 4'hA || tdo !== exp_tdo()) begin
      errors++; $display("FAIL resume_shift_ir: got %h tdo=%b expected %h tdo=%b",
                         tap_state, tdo, 4'hA, exp_tdo());
    end
    step(1'b0, b[2]);
    step(1'b1, b[3]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if (ir_out !== b || ir_out !== m_out) begin
      errors++; $display("FAIL pause_ir_load: got %b expected %b", ir_out, b);
    end
  endtask

  task automatic test_dr_scan();
    logic         seq  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic         pat  [3] = '{1'b1, 1'b0, 1'b1};
    logic [W-1:0] prev;
    int           n_cap, n_sh, n_upd, k;
    prev  = ir_out;
    n_cap = 0; n_sh = 0; n_upd = 0; k = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_st == 4 && k < 3) begin
        set_dr(pat[k]);
        checks++;
        if (tdo !== pat[k] || tdo_en !== 1'b1) begin
          errors++; $display("FAIL dr_tdo[%0d]: got tdo=%b en=%b expected tdo=%b en=1",
                             k, tdo, tdo_en, pat[k]);
        end
        k++;
      end else begin
        set_dr($urandom_range(0, 1) == 1);
        checks++;
        if (tdo !== exp_tdo()) begin
          errors++; $display("FAIL dr_idle_tdo[%0d]: got %b expected %b", i, tdo, exp_tdo());
        end
      end
      n_cap += int'(capture_dr);
      n_sh  += int'(shift_dr);
      n_upd += int'(update_dr);
      step(seq[i], $urandom_range(0, 1) == 1);
    end
    checks++;
    if (n_cap != 1 || n_sh != 3 || n_upd != 1) begin
      errors++; $display("FAIL dr_strobe_counts: got cap=%0d sh=%0d upd=%0d expected 1 3 1",
                         n_cap, n_sh, n_upd);
    end
    checks++;
    if (ir_out !== prev || tap_state !== 4'hC) begin
      errors++; $display("FAIL dr_scan_ir_hold: got %b/%h expected %b/%h",
                         ir_out, tap_state, prev, 4'hC);
    end
  endtask

  task automatic test_async_mid_shift();
    load_ir(4'b1011);
    checks++;
    if (ir_out !== 4'b1011) begin
      errors++; $display("FAIL ir_load_1011: got %b expected %b", ir_out, 4'b1011);
    end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (ir_out !== 4'b0000 || tap_state !== 4'hF || tdo_en !== 1'b0 || tdo !== 1'b0) begin
      errors++; $display("FAIL async_reset: got ir=%b st=%h en=%b tdo=%b expected 0000 f 0 0",
                         ir_out, tap_state, tdo_en, tdo);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 1'b0);
    checks++;
    if (tap_state !== 4'hC || ir_out !== 4'b0000) begin
      errors++; $display("FAIL post_reset_rti: got %h/%b expected %h/%b",
                         tap_state, ir_out, 4'hC, 4'b0000);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_dr($urandom_range(0, 1) == 1);
      checks++;
      if (tap_state !== enc[m_st] || ir_out !== m_out || tdo !== exp_tdo()
          || tdo_en !== (m_st == 4 || m_st == 11) || capture_dr !== (m_st == 3)
          || shift_dr !== (m_st == 4) || update_dr !== (m_st == 8)) begin
        errors++;
        $display("FAIL random[%0d]: got st=%h ir=%b tdo=%b en=%b c/s/u=%b%b%b expected st=%h ir=%b tdo=%b",
                 i, tap_state, ir_out, tdo, tdo_en, capture_dr, shift_dr, update_dr,
                 enc[m_st], m_out, exp_tdo());
      end
      // Bias TMS low a little so the walk spends time in the shift/pause loops.
      step($urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_ir_capture_shift();
    test_tms_reset();
    test_pause_ir();
    test_dr_scan();
    test_async_mid_shift();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tap_ir_ctrl.md
Name: tap_ir_ctrl

Overview:
TAP controller and instruction register front end for the JTAG block. It runs the IEEE 1149.1 16-state TAP state machine from TMS and shifts, captures and updates the instruction register. It drives the parallel instruction word consumed by the downstream instruction decoder. It also produces the capture/shift/update strobes for the data-register path and muxes TDO.

Parameters:
instr_width, 4, instruction register length in bits; minimum 3.
bypass_op, '0 (all zeros), opcode loaded into ir_out on reset and in Test-Logic-Reset.

Ports:
clk  input  1  TCK-domain clock; all state changes on posedge.
reset_n  input  1  asynchronous, active-low reset.
tms  input  1  test mode select, sampled on posedge clk.
tdi  input  1  test data in.
dr_tdo  input  1  serial output of the currently selected data register.
tdo  output  1  test data out.
tdo_en  output  1  high while in Shift-IR or Shift-DR.
ir_out  output  instr_width  latched instruction, feeds the decoder's instr_in.
capture_dr  output  1  high while state is Capture-DR.
shift_dr  output  1  high while state is Shift-DR.
update_dr  output  1  high while state is Update-DR.
tap_state  output  4  current TAP state, encoded per the jtag_pkg enum.

Behaviour:
- Reset (reset_n low, async): state = Test-Logic-Reset, ir_shift = '0, ir_out = bypass_op. All strobes, tdo and tdo_en read 0 while in reset.
- FSM:
  - Standard 16-state 1149.1 graph: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauIR, Ex2IR, UpdIR.
  - One transition per posedge, selected by tms.
  - Five consecutive tms=1 cycles from any state reach TLR.
  - TLR with tms=0 goes to RTI.
  - SelIR with tms=1 goes to TLR.
- Capture-IR: at a posedge with current state CapIR, ir_shift <= {(instr_width-2) zeros, 2'b01}.
- Shift-IR:
  - At every posedge with current state ShIR (including the exit edge with tms=1), ir_shift <= {tdi, ir_shift[instr_width-1:1]}.
  - LSB shifts out first.
- Update-IR:
  - At a posedge with current state UpdIR, ir_out <= ir_shift.
  - ir_out is therefore visible the cycle after UpdIR.
  - ir_out holds its value in all other states.
- TLR: at every posedge in TLR, ir_out <= bypass_op. This is the synchronous route; async reset also lands here.
- Pause-IR / Pause-DR: ir_shift and ir_out hold.
- tdo is combinational from registered state:
  - ShIR: tdo = ir_shift[0].
  - ShDR: tdo = dr_tdo.
  - Otherwise tdo = 0.
  - tdo_en = (state==ShIR) || (state==ShDR).
- DR strobes are pure decodes of the current state (Moore), one cycle wide per state visit. Pause states hold shift_dr low.
- The IR path never touches DR-path strobes, and the DR path never touches ir_shift or ir_out.
- reset_n asserted mid-shift: ir_out returns to bypass_op immediately. The partially shifted value is discarded.

Decomposition:
- jtag_pkg holds:
  - tap_state_t, 4-bit enum of the 16 states, fixed encoding, TLR = 4'hF.
  - Localparam helper for the IR capture pattern 2'b01.
  - The bypass_op default.
- Sub-module tap_fsm contains only the state register and next-state logic, and outputs tap_state_t.
- tap_ir_ctrl instantiates tap_fsm and adds the IR shift/update registers, strobes and tdo mux.

Test Plan:
- Async reset then release with tms=0 for 2 clk -> tap_state = RTI, ir_out = 4'b0000, all strobes 0, tdo_en 0.
- From RTI: tms 1,1,0,0, then shift tdi 1,1,1,0 (tms=1 on the last bit), then tms 1,0 -> tdo during shift = 1,0,0,0 (capture 0001), ir_out = 4'b0111 one cycle after UpdIR, then RTI.
- Load 4'b0010, then apply five tms=1 cycles from ShDR -> reach TLR, ir_out = 4'b0000 (bypass).
- Enter ShIR, shift 2 bits, go Ex1IR -> PauIR for 3 cycles -> Ex2IR -> ShIR, shift 2 more bits -> ir_out equals the 4 bits in order; ir_shift unchanged during the pause.
- DR scan with dr_tdo toggling 1,0,1 -> capture_dr high exactly 1 cycle, shift_dr high 3 cycles, tdo mirrors dr_tdo, update_dr 1 cycle, ir_out unchanged.
- reset_n pulsed low mid-ShIR after loading 4'b1011 previously -> ir_out = 4'b0000 asynchronously, tap_state = TLR.
